// File: rtl/tlv_mem_loader.sv
// TLV byte-stream decoder: packs value bytes little-endian into per-channel load memories
// and returns one status byte per frame. Define TLV_CHECKSUM_EN to require an XOR trailer byte.
module tlv_mem_loader #(
  parameter int NUM_CH     = 2,
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int LEN_BYTES  = 1,
  parameter int TIMEOUT    = 1000000,
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  wr_en,
  output logic [SEL_W-1:0]      wr_sel,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  start,
  output logic [7:0]            resp_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_lost,
  output logic                  busy
);
  localparam int LANES  = WORD_WIDTH / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LEN_W  = 8 * LEN_BYTES;
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_VAL  = 3'd2,
`ifdef TLV_CHECKSUM_EN
    S_CHK  = 3'd3,
`endif
    S_END  = 3'd4
  } state_t;

`ifdef TLV_CHECKSUM_EN
  localparam state_t AFTER_VAL = S_CHK;
`else
  localparam state_t AFTER_VAL = S_END;
`endif

  state_t                state_reg, state_next;
  logic [7:0]            type_reg, chk_reg;
  logic [LEN_W-1:0]      len_reg, rem_reg;
  logic                  len_cnt_reg;
  logic [LANE_W-1:0]     lane_reg;
  logic [WORD_WIDTH-1:0] word_reg, word_merge;
  logic                  ovf_reg, bad_chk_reg;
  logic [TO_W-1:0]       to_cnt_reg;
  logic [ADDR_W:0]       addr_reg [NUM_CH];
  logic                  wr_en_reg, start_reg, resp_valid_reg, resp_lost_reg;
  logic [SEL_W-1:0]      wr_sel_reg;
  logic [ADDR_W-1:0]     wr_addr_reg;
  logic [WORD_WIDTH-1:0] wr_data_reg;
  logic [7:0]            resp_data_reg;

  logic [LEN_W-1:0]      len_shift;
  logic                  last_len, last_val, word_done, timeout, new_type, resp_new;
  logic                  is_ch, is_clr, is_start;
  logic [SEL_W-1:0]      ch_idx;
  logic [ADDR_W:0]       cur_addr;
  logic [7:0]            status;

  // Incoming byte replaces its lane; lanes above it are still zero from the last write.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign word_merge[gi*8 +: 8] = (lane_reg == LANE_W'(gi)) ? rx_data : word_reg[gi*8 +: 8];
  end

  assign len_shift = LEN_W'({len_reg, rx_data});
  assign last_len  = (len_cnt_reg == 1'(LEN_BYTES - 1));
  assign last_val  = (rem_reg == LEN_W'(1));
  assign word_done = (lane_reg == LANE_W'(LANES - 1)) || last_val;
  assign is_ch     = (type_reg != 8'h00) && (int'(type_reg) <= NUM_CH);
  assign is_clr    = (type_reg == 8'hF0);
  assign is_start  = (type_reg == 8'hFF);
  assign ch_idx    = SEL_W'(type_reg - 8'd1);
  assign cur_addr  = addr_reg[ch_idx];
  assign new_type  = rx_valid && (rx_data != 8'h00) &&
                     ((state_reg == S_IDLE) || (state_reg == S_END));
  assign timeout   = (state_reg != S_IDLE) && (state_reg != S_END) && !rx_valid &&
                     (to_cnt_reg == TO_W'(TIMEOUT - 1));
  assign resp_new  = timeout || (state_reg == S_END);

  always_comb begin
    status = 8'h06;
    if (ovf_reg)                       status = 8'h18;
    if (bad_chk_reg)                   status = 8'h1C;
    if (!is_ch && !is_clr && !is_start) status = 8'h15;
    if (timeout)                       status = 8'h1B;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (new_type) state_next = S_LEN;
      S_LEN:  if (rx_valid && last_len) state_next = (len_shift == '0) ? AFTER_VAL : S_VAL;
      S_VAL:  if (rx_valid && last_val) state_next = AFTER_VAL;
`ifdef TLV_CHECKSUM_EN
      S_CHK:  if (rx_valid) state_next = S_END;
`endif
      S_END:  state_next = new_type ? S_LEN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (timeout) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      type_reg       <= '0;
      chk_reg        <= '0;
      len_reg        <= '0;
      rem_reg        <= '0;
      len_cnt_reg    <= 1'b0;
      lane_reg       <= '0;
      word_reg       <= '0;
      ovf_reg        <= 1'b0;
      bad_chk_reg    <= 1'b0;
      to_cnt_reg     <= '0;
      wr_en_reg      <= 1'b0;
      wr_sel_reg     <= '0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      start_reg      <= 1'b0;
      resp_data_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_lost_reg  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) addr_reg[i] <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      start_reg <= 1'b0;

      if ((state_reg == S_IDLE) || (state_reg == S_END) || rx_valid) to_cnt_reg <= '0;
      else                                                         to_cnt_reg <= to_cnt_reg + 1'b1;

      if (new_type) begin
        type_reg    <= rx_data;
        chk_reg     <= rx_data;
        len_reg     <= '0;
        len_cnt_reg <= 1'b0;
        lane_reg    <= '0;
        word_reg    <= '0;
        ovf_reg     <= 1'b0;
        bad_chk_reg <= 1'b0;
      end

      if (rx_valid && (state_reg == S_LEN)) begin
        len_reg     <= len_shift;
        len_cnt_reg <= ~len_cnt_reg;
        chk_reg     <= chk_reg ^ rx_data;
        if (last_len) rem_reg <= len_shift;
      end

      if (rx_valid && (state_reg == S_VAL)) begin
        chk_reg <= chk_reg ^ rx_data;
        rem_reg <= rem_reg - 1'b1;
        if (word_done) begin
          lane_reg <= '0;
          word_reg <= '0;
          if (is_ch) begin
            // A full channel drops further words but keeps consuming the frame.
            if (cur_addr == (ADDR_W+1)'(DEPTH)) begin
              ovf_reg <= 1'b1;
            end else begin
              wr_en_reg        <= 1'b1;
              wr_sel_reg       <= ch_idx;
              wr_addr_reg      <= cur_addr[ADDR_W-1:0];
              wr_data_reg      <= word_merge;
              addr_reg[ch_idx] <= cur_addr + 1'b1;
            end
          end
        end else begin
          lane_reg <= lane_reg + 1'b1;
          word_reg <= word_merge;
        end
      end

`ifdef TLV_CHECKSUM_EN
      if (rx_valid && (state_reg == S_CHK)) bad_chk_reg <= (rx_data != chk_reg);
`endif

      if (state_reg == S_END) begin
        if (is_clr)   for (int i = 0; i < NUM_CH; i++) addr_reg[i] <= '0;
        if (is_start) start_reg <= 1'b1;
      end

      // A new status always wins; it only counts as lost if the old one was not taken this cycle.
      if (resp_new) begin
        resp_data_reg  <= status;
        resp_valid_reg <= 1'b1;
        if (resp_valid_reg && !resp_ready) resp_lost_reg <= 1'b1;
      end else if (resp_valid_reg && resp_ready) begin
        resp_valid_reg <= 1'b0;
      end
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_sel     = wr_sel_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign start      = start_reg;
  assign resp_data  = resp_data_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_lost  = resp_lost_reg;
  assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_tlv_mem_loader.sv
// Directed scoreboard bench for tlv_mem_loader (DEPTH 2, short timeout); frames get an
// XOR trailer automatically when TLV_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_tlv_mem_loader;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        resp_ready = 1'b1;
  logic        wr_en;
  logic [0:0]  wr_sel;
  logic [0:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_lost;
  logic        busy;

  always #5 clk = ~clk;

  tlv_mem_loader #(
    .NUM_CH(2), .WORD_WIDTH(32), .DEPTH(2), .LEN_BYTES(1), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .resp_data(resp_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_lost(resp_lost), .busy(busy)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          start_cnt = 0;
  int          start_snap;
  logic [33:0] wr_q [$];
  logic [7:0]  resp_q [$];
  logic [7:0]  fb [$];
  logic [33:0] exp_w;
  logic [7:0]  exp_r;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (start) start_cnt++;
      if (wr_en) begin
        $display("write sel=%0d addr=%0d data=0x%08h", wr_sel, wr_addr, wr_data);
        if (wr_q.size() == 0) check("wr_unexpected", 64'(wr_en), 64'd0);
        else begin
          exp_w = wr_q.pop_front();
          check("wr", 64'({wr_sel, wr_addr, wr_data}), 64'(exp_w));
        end
      end
      if (resp_valid && resp_ready) begin
        $display("resp data=0x%02h lost=%0d", resp_data, resp_lost);
        if (resp_q.size() == 0) check("resp_unexpected", 64'(resp_valid), 64'd0);
        else begin
          exp_r = resp_q.pop_front();
          check("resp", 64'(resp_data), 64'(exp_r));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_raw();
    foreach (fb[i]) begin
      rx_data  = fb[i];
      rx_valid = 1'b1;
      tick(1);
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    fb.delete();
    tick(1);
  endtask

  task automatic send_frame();
`ifdef TLV_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (fb[i]) x ^= fb[i];
    fb.push_back(x);
`endif
    send_raw();
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((wr_q.size() != 0 || resp_q.size() != 0) && k < 200) begin
      tick(1);
      k++;
    end
    check({tag, "_wr_left"}, 64'(wr_q.size()), 64'd0);
    check({tag, "_resp_left"}, 64'(resp_q.size()), 64'd0);
    wr_q.delete();
    resp_q.delete();
    tick(4);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(2);

    // Reset mid-frame: frame abandoned, no flush, no response.
    fb = {8'h01, 8'h04, 8'hAA};
    send_raw();
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    check("rst_ctrl", 64'({wr_en, start, resp_valid, resp_lost, busy}), 64'd0);
    check("rst_data", 64'({wr_sel, wr_addr, wr_data, resp_data}), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(10);
    check("rst_busy", 64'(busy), 64'd0);

    // Full word packing.
    wr_q.push_back({1'b0, 1'b0, 32'hDDCCBBAA});
    resp_q.push_back(8'h06);
    fb = {8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame();
    drain("pack");

    // Partial flush and address persistence, with the transmitter stalled.
    resp_ready = 1'b0;
    wr_q.push_back({1'b1, 1'b0, 32'h00332211});
    wr_q.push_back({1'b1, 1'b1, 32'h00000044});
    fb = {8'h02, 8'h03, 8'h11, 8'h22, 8'h33};
    send_frame();
    fb = {8'h02, 8'h01, 8'h44};
    send_frame();
    tick(5);
    @(negedge clk);
    check("lost_valid", 64'(resp_valid), 64'd1);
    check("lost_flag", 64'(resp_lost), 64'd1);
    check("lost_data", 64'(resp_data), 64'h06);
    tick(1);
    resp_q.push_back(8'h06);
    resp_ready = 1'b1;
    drain("flush");

    // Bad type, then start.
    resp_q.push_back(8'h15);
    fb = {8'h07, 8'h01, 8'h55};
    send_frame();
    drain("badtype");
    start_snap = start_cnt;
    resp_q.push_back(8'h06);
    fb = {8'hFF, 8'h00};
    send_frame();
    drain("start");
    check("start_pulses", 64'(start_cnt - start_snap), 64'd1);

    // Clear, overflow past DEPTH, clear again, reload at address 0.
    resp_q.push_back(8'h06);
    fb = {8'hF0, 8'h00};
    send_frame();
    wr_q.push_back({1'b0, 1'b0, 32'h13121110});
    wr_q.push_back({1'b0, 1'b1, 32'h17161514});
    resp_q.push_back(8'h18);
    fb = {8'h01, 8'h0C};
    for (int i = 0; i < 12; i++) fb.push_back(8'(8'h10 + i));
    send_frame();
    drain("ovf");
    resp_q.push_back(8'h06);
    fb = {8'hF0, 8'h00};
    send_frame();
    wr_q.push_back({1'b0, 1'b0, 32'hD4C3B2A1});
    resp_q.push_back(8'h06);
    fb = {8'h01, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_frame();
    drain("clear");

    // Timeout mid-value: no write, idle again, status 0x1B.
    resp_q.push_back(8'h1B);
    fb = {8'h01, 8'h04, 8'hAA};
    send_raw();
    drain("timeout");
    check("timeout_busy", 64'(busy), 64'd0);

`ifdef TLV_CHECKSUM_EN
    resp_q.push_back(8'h06);
    fb = {8'hF0, 8'h00};
    send_frame();
    wr_q.push_back({1'b0, 1'b0, 32'h0000005A});
    resp_q.push_back(8'h06);
    fb = {8'h01, 8'h01, 8'h5A, 8'h5A};
    send_raw();
    drain("chk_good");
    wr_q.push_back({1'b0, 1'b1, 32'h0000005A});
    resp_q.push_back(8'h1C);
    fb = {8'h01, 8'h01, 8'h5A, 8'h00};
    send_raw();
    drain("chk_bad");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tlv_mem_loader.md
Name: tlv_mem_loader

Overview:
- Parametrised byte-stream TLV command decoder that sits between the UART receiver and the on-chip load memories (seed, public key, and so on).
- Packs value bytes little-endian into WORD_WIDTH words and writes them to one of NUM_CH channel memories, selected by the TLV type.
- Keeps a per-channel write address that persists across frames, so large objects can be split over many frames.
- Issues a one-cycle start pulse to the DUT, and returns one status byte per frame for the UART transmitter.

Parameters:
- NUM_CH, 2, number of target memories; type t in 1..NUM_CH selects channel t-1.
- WORD_WIDTH, 32, memory word width in bits; must be a multiple of 8, range 8..64.
- DEPTH, 16, words per channel.
- LEN_BYTES, 1, width of the length field in bytes (1 or 2, big-endian).
- TIMEOUT, 1000000, maximum idle clocks between bytes inside a frame.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe qualifying rx_data
- wr_en  out  1  memory write strobe
- wr_sel  out  clog2(NUM_CH) (min 1)  target channel index
- wr_addr  out  clog2(DEPTH)  word address within the channel
- wr_data  out  WORD_WIDTH  packed word
- start  out  1  one-cycle start pulse to the DUT
- resp_data  out  8  status byte
- resp_valid  out  1  status byte available
- resp_ready  in  1  transmitter accepts resp_data
- resp_lost  out  1  sticky: a pending status byte was overwritten
- busy  out  1  high while the FSM is not in S_IDLE

Behaviour:
- Reset:
  - Synchronous and active-high; one clock; reset is synchronous and active-high.
  - All outputs go to 0, the FSM goes to S_IDLE, all channel addresses clear to 0, and the byte packer clears.
  - Reset mid-frame abandons the frame silently: no flush write and no response.
- FSM states are S_IDLE, S_LEN, S_VAL, S_CHK (only with the optional feature), and S_END.
- S_IDLE:
  - A byte of 0x00 is a sync byte and is ignored.
  - Any other byte is latched as the type; go to S_LEN.
- S_LEN:
  - Collects LEN_BYTES bytes, MSB first.
  - If the length is 0, go to S_CHK (feature on) or S_END; otherwise go to S_VAL.
- S_VAL:
  - Each value byte is placed into byte lane (byte_cnt mod WORD_WIDTH/8).
  - When the last lane fills, the word is written.
  - After the final value byte, any partial word is flushed with its unfilled upper lanes set to zero. The FSM then goes to S_CHK or S_END.
- Write timing and addressing:
  - wr_en is registered: it asserts the clock after the rx_valid of the byte that completes (or flushes) a word, for one cycle.
  - wr_addr is the channel's current address, which then increments.
  - The internal address is clog2(DEPTH)+1 bits. If the address equals DEPTH, the write is suppressed, the address does not change, and the frame overflow flag is set.
- Type handling:
  - 1..NUM_CH: load the selected channel.
  - 0xF0: clear all channel addresses at frame end; value bytes are ignored.
  - 0xFF: pulse start for one cycle at frame end; value bytes are ignored.
  - Any other type: bytes are consumed, no writes occur, and the status is NAK.
- Timeout:
  - In any state other than S_IDLE, a counter counts clocks since the last rx_valid.
  - When it reaches TIMEOUT, the FSM returns to S_IDLE with no flush write, and status 0x1B is issued.
- S_END (one cycle):
  - Produces the status byte with priority 0x15 bad type > 0x1C checksum > 0x18 overflow > 0x06 ACK.
  - Applies the 0xF0 and 0xFF actions, then returns to S_IDLE.
- Response handshake:
  - resp_valid is set the cycle after the frame's last byte (or after the timeout).
  - It holds, with resp_data stable, until resp_valid && resp_ready.
  - If a new status arrives while one is still pending, the new status replaces the old one and resp_lost is set. resp_lost clears only on reset.
  - If a new status arrives in the same cycle that the old one is accepted, the new status becomes pending and resp_lost is not set.
- Throughput: one byte per cycle is sustainable; rx_valid may be asserted back-to-back.

Optional Feature:
- Macro TLV_CHECKSUM_EN.
- When defined:
  - Every frame carries one extra byte after the value bytes, equal to the XOR of the type, all length bytes, and all value bytes. This byte is received in S_CHK.
  - A mismatch yields status 0x1C.
  - Writes already issued for that frame are not rolled back.
- When undefined: S_CHK does not exist, frames have no trailer, and status 0x1C is never produced.

Test Plan:
- Reset behaviour: assert rst for 2 cycles mid-frame -> all outputs are 0, busy is 0, and no response follows. Then send 01 04 AA BB CC DD -> a write to channel 0, addr 0.
- Word packing: send 01 04 AA BB CC DD (WORD_WIDTH 32) -> one write with wr_sel 0, wr_addr 0, wr_data 0xDDCCBBAA, then resp 0x06 on the following cycle.
- Partial flush and address persistence: send 02 03 11 22 33 then 02 01 44 -> channel 1 gets addr 0 = 0x00332211 and addr 1 = 0x00000044, with two ACKs. Hold resp_ready low during this -> resp_lost is 1 and resp_data is 0x06.
- Bad type, then start: send 07 01 55 -> no write, resp 0x15. Then send FF 00 -> start high for exactly 1 cycle, resp 0x06.
- Overflow and clear (DEPTH 2): send 01 0C followed by 12 bytes -> writes only to addr 0 and addr 1, resp 0x18. Then send F0 00, then 01 04 ... -> the write lands at addr 0.
- Timeout and checksum: send 01 04 AA then no bytes for TIMEOUT cycles -> no write, busy drops, resp 0x1B. With TLV_CHECKSUM_EN, send 01 01 5A 5A (0x01^0x01^0x5A = 0x5A) -> write, then ACK. Send 01 01 5A 00 -> write, then resp 0x1C.
